mux9_rr_arbiter: RTL and testbench
==================================

Name: mux9_rr_arbiter

Overview:
- Round-robin arbiter that shares one 9-input, WIDTH-bit selection mux among 9 requesters (write-back and operand sources).
- Produces the registered 4-bit mux select and one-hot grant, and uses a valid/ready handshake with the single downstream consumer.
- Requests 0..8 map directly to mux inputs 0..8.
- Sits between the requesting units and the mux select pin; the data path stays outside this block.

Parameters:
N_REQ, 9, number of requesters; fixed to 9; other values unsupported.
SEL_W, 4, select width; must be ≥ clog2(N_REQ).

Ports:
clk  in  1  system clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
req  in  9  per-requester request level; held until matching ack.
req_mask  in  9  1 = requester eligible; sampled only at arbitration.
sel  out  4  registered mux select = index of granted requester.
grant  out  9  registered one-hot grant; all-zero when idle.
out_valid  out  1  selected data valid toward consumer.
out_ready  in  1  consumer accepts when out_valid & out_ready.
ack  out  9  combinational; equals grant when out_valid & out_ready, else 0.
err_drop  out  1  sticky; set when a granted requester drops req before ack.
busy  out  1  equals out_valid.

Behaviour:
- Reset (async assert, sync-deassert handled externally): sel=0, grant=0, out_valid=0, err_drop=0, last pointer ptr=8, state=IDLE.
- Eligible set is E = req & req_mask.
- Pick order: the first set bit of E searching ptr+1, ptr+2, …, wrapping 8→0, with ptr itself checked last.
- States:
  - IDLE: if E≠0, next edge loads grant/sel with the pick, sets out_valid=1, and moves to GRANT. Otherwise it stays in IDLE.
  - GRANT: out_valid=1 and grant/sel stay stable until a transfer or a drop.
- Transfer (out_valid & out_ready & req[sel]):
  - ack[sel]=1 for that cycle; ptr←sel.
  - Requests are re-arbitrated in the same cycle, excluding the winner, i.e. using E & ~grant.
  - If the remaining set is non-zero, the next edge loads the new winner with no bubble and stays in GRANT.
  - Otherwise the next edge goes to IDLE with out_valid=0, grant=0, and sel holding its last value.
- Drop (in GRANT, req[sel]=0 and no transfer):
  - Next edge: out_valid=0, grant=0, state=IDLE, err_drop←1; ptr unchanged; no ack.
  - If out_ready=1 in the same cycle as the drop, the drop wins and no ack is issued.
- Mask change during GRANT does not affect the current grant; it applies at the next arbitration.
- Single requester with req held continuously: after each ack it is not re-granted in the same cycle. It is re-granted from IDLE one cycle later, giving a 1-cycle bubble.
- Latency:
  - req rising while IDLE → out_valid at the next edge, i.e. 1 cycle.
  - ack is combinational in the accept cycle.
- sel and grant are always mutually consistent (grant = 1<<sel whenever out_valid=1).
- err_drop is cleared only by reset.
- Reset mid-GRANT: all outputs return to reset values immediately, and ack goes to 0 combinationally.

Decomposition:
- Shared package: state encoding (IDLE=1'b0, GRANT=1'b1), the N_REQ and SEL_W constants, and the reset value of ptr (8).
- Sub-module rr_pick9:
  - Combinational; inputs are a 9-bit eligible vector and a 4-bit ptr.
  - Outputs are found, a 4-bit index, and a one-hot vector.
  - Used once, with the eligible vector gated per the rules above.

Test Plan:
1. Reset, then req=9'h001, mask=9'h1FF, out_ready=1 → out_valid=1, sel=0, grant=9'h001 one cycle later; ack=9'h001 in that cycle; out_valid returns to 0 the next cycle.
2. req=9'h1FF held, out_ready=1, each requester drops req after its ack → sel sequence 0,1,2,…,8 on consecutive cycles with no bubble; then IDLE.
3. req=9'h104 constant, out_ready=0 for 5 cycles, then 1 → sel=2 stable for 6 cycles; after ack the next grant is sel=8, and then sel=2 again (wrap).
4. Grant sel=3 active with out_ready=0, then req[3] drops → next cycle out_valid=0, grant=0, err_drop=1; err_drop remains 1 until reset_n low.
5. req=9'h0FF, mask=9'h0F0 → first grant is sel=4; clearing mask bit 5 during sel=4's grant still keeps sel=4 until ack, and the next grant is sel=6.
6. reset_n asserted low mid-GRANT (sel=7), asynchronously between edges → out_valid, grant, ack, err_drop go to 0 and sel to 0 without waiting for clk; after release, req=9'h181 is granted in order sel=0, 7, 8.

Source files
------------

// File: rtl/mux9_rr_arbiter_pkg.sv
// Shared constants and state encoding for the 9-way round-robin mux arbiter.
// No logic; latency n/a.
// Backpressure n/a.
package mux9_rr_arbiter_pkg;

    localparam int N_REQ = 9;
    localparam int SEL_W = 4;

    // Pointer starts at the last requester so requester 0 wins the first pick
    localparam logic [SEL_W-1:0] PTR_RST = 4'd8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/mux9_rr_arbiter_rr_pick9.sv
// Round-robin picker: first eligible bit after ptr, wrapping 8->0, ptr itself last.
// Latency: purely combinational.
// Backpressure: none; the caller gates the eligible vector.
module rr_pick9
    import mux9_rr_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] elig,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx,
    output logic [N_REQ-1:0] onehot
);

    logic [SEL_W-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = ptr;
        for (int i = 0; i < N_REQ; i++) begin
            cand = (cand == SEL_W'(N_REQ - 1)) ? '0 : cand + 1'b1;
            if (elig[cand] && !found) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        onehot = found ? (N_REQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/mux9_rr_arbiter.sv
// Round-robin arbiter driving a registered 9:1 mux select and one-hot grant.
// Latency: 1 cycle from eligible request to out_valid; ack is combinational.
// Backpressure: grant holds while out_ready is low; a dropped request ends the grant.
module mux9_rr_arbiter
    import mux9_rr_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] req_mask,
    input  logic             out_ready,
    output logic [SEL_W-1:0] sel,
    output logic [N_REQ-1:0] grant,
    output logic             out_valid,
    output logic [N_REQ-1:0] ack,
    output logic             err_drop,
    output logic             busy
);

    state_t           state, state_nxt;
    logic [SEL_W-1:0] ptr, ptr_nxt, sel_nxt;
    logic [N_REQ-1:0] grant_nxt;
    logic             err_nxt;

    logic [N_REQ-1:0] elig_all, pick_elig, pick_onehot;
    logic [SEL_W-1:0] pick_ptr, pick_idx;
    logic             pick_found;
    logic             req_sel, xfer, drop;

    assign elig_all  = req & req_mask;
    assign req_sel   = req[sel];
    assign out_valid = (state == GRANT);
    assign busy      = out_valid;
    assign xfer      = out_valid & out_ready & req_sel;
    assign drop      = out_valid & ~req_sel;
    assign ack       = xfer ? grant : '0;

    // On a transfer the winner is excluded and the search restarts just past it
    assign pick_elig = xfer ? (elig_all & ~grant) : elig_all;
    assign pick_ptr  = xfer ? sel : ptr;

    rr_pick9 u_pick (
        .elig   (pick_elig),
        .ptr    (pick_ptr),
        .found  (pick_found),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        sel_nxt   = sel;
        grant_nxt = grant;
        err_nxt   = err_drop;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt = GRANT;
                    sel_nxt   = pick_idx;
                    grant_nxt = pick_onehot;
                end
            end
            GRANT: begin
                if (xfer) begin
                    ptr_nxt = sel;
                    if (pick_found) begin
                        sel_nxt   = pick_idx;
                        grant_nxt = pick_onehot;
                    end else begin
                        state_nxt = IDLE;
                        grant_nxt = '0;
                    end
                end else if (drop) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                    err_nxt   = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            ptr      <= PTR_RST;
            sel      <= '0;
            grant    <= '0;
            err_drop <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            sel      <= sel_nxt;
            grant    <= grant_nxt;
            err_drop <= err_nxt;
        end
    end

endmodule

// File: tb/tb_mux9_rr_arbiter.sv
// Directed bench for mux9_rr_arbiter with a scoreboard of expected winners.
// A negedge monitor pops the queue on every transfer; inline checks cover idle/drop/reset.
// Inputs change 1 time unit after the rising edge.
module tb_mux9_rr_arbiter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [8:0] req;
    logic [8:0] req_mask;
    logic       out_ready;
    logic [3:0] sel;
    logic [8:0] grant;
    logic       out_valid;
    logic [8:0] ack;
    logic       err_drop;
    logic       busy;

    int          n_vec = 0;
    int          n_err = 0;
    int unsigned exp_q[$];

    always #5 clk = ~clk;

    mux9_rr_arbiter dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .req_mask  (req_mask),
        .out_ready (out_ready),
        .sel       (sel),
        .grant     (grant),
        .out_valid (out_valid),
        .ack       (ack),
        .err_drop  (err_drop),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: a transfer is valid & ready while the granted line still requests
    always @(negedge clk) begin
        int unsigned e;
        if (reset_n && out_valid && out_ready && ((req & grant) != 9'd0)) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_unexpected: transfer on sel=%0d with nothing expected", sel);
            end else begin
                e = exp_q.pop_front();
                chk("sb_sel", 32'(sel), e);
                chk("sb_grant", 32'(grant), 32'(1) << e);
                chk("sb_ack", 32'(ack), 32'(1) << e);
                chk("sb_busy", 32'(busy), 32'd1);
            end
        end
    end

    task automatic do_reset();
        reset_n   = 1'b0;
        req       = '0;
        out_ready = 1'b0;
        req_mask  = 9'h1FF;
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_err", 32'(err_drop), 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One cycle; optionally checks out_valid, then retires whatever was acked
    task automatic cyc_drop(input string nm, input int expv);
        logic [8:0] a;
        @(negedge clk);
        if (expv >= 0) chk(nm, 32'(out_valid), 32'(expv));
        a = ack;
        @(posedge clk);
        #1;
        req = req & ~a;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        req       = '0;
        req_mask  = 9'h1FF;
        out_ready = 1'b0;

        // 1: single request, one-cycle latency, back to idle after ack
        do_reset();
        req = 9'h001;
        out_ready = 1'b1;
        exp_q.push_back(0);
        cyc_drop("t1_pre", 0);
        cyc_drop("t1_valid", 1);
        @(negedge clk);
        chk("t1_idle", 32'(out_valid), 32'd0);
        chk("t1_ack0", 32'(ack), 32'd0);

        // 2: all requesters, back-to-back grants 0..8 without a bubble
        do_reset();
        req = 9'h1FF;
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) exp_q.push_back(i);
        cyc_drop("t2_pre", 0);
        for (int i = 0; i < 9; i++) cyc_drop("t2_nobubble", 1);
        @(negedge clk);
        chk("t2_idle", 32'(out_valid), 32'd0);
        chk("t2_grant0", 32'(grant), 32'd0);
        chk("t2_selhold", 32'(sel), 32'd8);

        // 3: backpressure holds sel=2, then 2 -> 8 -> 2 wrap
        do_reset();
        req = 9'h104;
        exp_q.push_back(2);
        exp_q.push_back(8);
        exp_q.push_back(2);
        cyc_drop("t3_pre", 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_hold_sel", 32'(sel), 32'd2);
            chk("t3_hold_ack", 32'(ack), 32'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;

        // 4: drop while granted, drop beats out_ready, err_drop sticky
        do_reset();
        req = 9'h008;
        cyc_drop("t4_pre", 0);
        @(negedge clk);
        chk("t4_sel", 32'(sel), 32'd3);
        @(posedge clk);
        #1;
        req = 9'h000;
        out_ready = 1'b1;
        @(negedge clk);
        chk("t4_noack", 32'(ack), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t4_valid0", 32'(out_valid), 32'd0);
        chk("t4_grant0", 32'(grant), 32'd0);
        chk("t4_err", 32'(err_drop), 32'd1);
        @(posedge clk);
        #1;
        req = 9'h002;
        exp_q.push_back(1);
        cyc_drop("t4_re_pre", 0);
        cyc_drop("t4_re", 1);
        cyc_drop("t4_re_idle", 0);
        chk("t4_err_sticky", 32'(err_drop), 32'd1);

        // 5: mask restricts picks; mask change mid-grant applies next time
        do_reset();
        req = 9'h0FF;
        req_mask = 9'h0F0;
        cyc_drop("t5_pre", 0);
        @(negedge clk);
        chk("t5_first", 32'(sel), 32'd4);
        @(posedge clk);
        #1;
        req_mask = 9'h0D0;
        @(negedge clk);
        chk("t5_keep", 32'(sel), 32'd4);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        exp_q.push_back(4);
        exp_q.push_back(6);
        cyc_drop("t5_a", 1);
        cyc_drop("t5_b", 1);
        out_ready = 1'b0;

        // 6: asynchronous reset mid-grant, then 0 -> 7 -> 8 from reset pointer
        do_reset();
        req = 9'h080;
        cyc_drop("t6_pre", 0);
        @(negedge clk);
        chk("t6_sel7", 32'(sel), 32'd7);
        #1;
        out_ready = 1'b1;
        #1;
        chk("t6_ack_pre", 32'(ack), 32'h080);
        reset_n = 1'b0;
        #1;
        chk("t6_arst_valid", 32'(out_valid), 32'd0);
        chk("t6_arst_grant", 32'(grant), 32'd0);
        chk("t6_arst_ack", 32'(ack), 32'd0);
        chk("t6_arst_sel", 32'(sel), 32'd0);
        chk("t6_arst_err", 32'(err_drop), 32'd0);
        req = 9'h181;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        exp_q.push_back(0);
        exp_q.push_back(7);
        exp_q.push_back(8);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) cyc_drop("t6_order", 1);
        @(negedge clk);
        chk("t6_idle", 32'(out_valid), 32'd0);
        chk("sb_final", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
